// File: rtl/angle_host_sequencer.sv
// -----------------------------------------------------------------------------
// angle_host_sequencer
//
// Host-side responder for the angle request handshake used by the filtered RAM
// swap control. After a `kick` it serves one projection scan of NO_OF_ANGLES
// angles. Each request on `hs_next_angle` is answered after a fixed lookup
// latency with a one-cycle `hs_next_angle_ack`. While the ack is high,
// `hs_angle` and `hs_has_next_angle` describe the angle being delivered.
//
// Parameters:
//   ANGLE_LENGTH  width of hs_angle
//   ANGLE_START   first angle of a scan
//   ANGLE_STEP    unsigned increment between consecutive angles
//   NO_OF_ANGLES  angles per scan (>= 1)
//   ACK_DELAY     cycles from the WAIT_REQ cycle that sees the request to the
//                 ack cycle (>= 1)
//
// Ports:
//   clk                input   system clock, rising edge
//   reset_n            input   asynchronous active-low reset
//   kick               input   start-of-scan pulse, only honoured when idle
//   hs_next_angle      input   level request from the swap control
//   hs_angle           output  angle delivered by the next ack
//   hs_has_next_angle  output  an undelivered angle remains in this scan
//   hs_next_angle_ack  output  single-cycle acknowledge
//   busy               output  scan in progress
//   done               output  single-cycle pulse after the last ack
//
// Every output comes straight from a flop. The control outputs are computed
// from the next-state values, so they line up with the state they describe
// and no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module angle_host_sequencer #(
    parameter int ANGLE_LENGTH = 8,
    parameter int ANGLE_START  = 0,
    parameter int ANGLE_STEP   = 1,
    parameter int NO_OF_ANGLES = 180,
    parameter int ACK_DELAY    = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    kick,
    input  logic                    hs_next_angle,
    output logic [ANGLE_LENGTH-1:0] hs_angle,
    output logic                    hs_has_next_angle,
    output logic                    hs_next_angle_ack,
    output logic                    busy,
    output logic                    done
);

    localparam int REM_W = $clog2(NO_OF_ANGLES + 1);
    localparam int DLY_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY + 1) : 1;

    localparam logic [ANGLE_LENGTH-1:0] START_VAL = ANGLE_LENGTH'(ANGLE_START);
    localparam logic [ANGLE_LENGTH-1:0] STEP_VAL  = ANGLE_LENGTH'(ANGLE_STEP);
    localparam logic [REM_W-1:0]        N_VAL     = REM_W'(NO_OF_ANGLES);
    localparam logic [DLY_W-1:0]        DLY_LOAD  = DLY_W'(ACK_DELAY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REQ,
        S_DELAY,
        S_ACK,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                  state, state_next;
    logic [ANGLE_LENGTH-1:0] angle, angle_next;
    logic [REM_W-1:0]        remaining, remaining_next;
    logic [DLY_W-1:0]        dly_cnt, dly_cnt_next;

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can
        // leave one unassigned and infer a latch.
        state_next     = state;
        angle_next     = angle;
        remaining_next = remaining;
        dly_cnt_next   = dly_cnt;

        case (state)
            S_IDLE: begin
                // Requests are ignored here; a request arriving together with
                // kick is picked up from WAIT_REQ onward.
                if (kick) begin
                    angle_next     = START_VAL;
                    remaining_next = N_VAL;
                    state_next     = S_WAIT_REQ;
                end
            end

            S_WAIT_REQ: begin
                if (hs_next_angle) begin
                    if (ACK_DELAY == 1) begin
                        state_next = S_ACK;
                    end else begin
                        dly_cnt_next = DLY_LOAD;
                        state_next   = S_DELAY;
                    end
                end
            end

            S_DELAY: begin
                // The request is already latched by being here, so a dropped
                // hs_next_angle does not cancel the pending ack.
                dly_cnt_next = dly_cnt - DLY_W'(1);
                if (dly_cnt_next == '0) begin
                    state_next = S_ACK;
                end
            end

            S_ACK: begin
                angle_next     = angle + STEP_VAL;
                remaining_next = remaining - REM_W'(1);
                if (remaining > REM_W'(1)) begin
                    state_next = S_HOLD;
                end else begin
                    state_next = S_DONE;
                end
            end

            S_HOLD: begin
                // One dead cycle gives the consumer time to drop its request,
                // so a request still high from the last ack is not served twice.
                state_next = S_WAIT_REQ;
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, datapath and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            angle             <= START_VAL;
            remaining         <= '0;
            dly_cnt           <= '0;
            hs_next_angle_ack <= 1'b0;
            hs_has_next_angle <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every flop loads
            // from the values present before the edge, whatever the order.
            state             <= state_next;
            angle             <= angle_next;
            remaining         <= remaining_next;
            dly_cnt           <= dly_cnt_next;
            hs_next_angle_ack <= (state_next == S_ACK);
            done              <= (state_next == S_DONE);
            busy              <= (state_next != S_IDLE);
            hs_has_next_angle <= (state_next != S_IDLE) && (remaining_next != '0);
        end
    end

    assign hs_angle = angle;

endmodule

// File: tb/tb_angle_host_sequencer.sv
// -----------------------------------------------------------------------------
// tb_angle_host_sequencer
//
// Three instances share clock and reset:
//   u_a : START=10,  STEP=60, N=3, DELAY=2  (main scan, table vectors)
//   u_b : START=200, STEP=60, N=2, DELAY=2  (angle wrap)
//   u_c : START=0,   STEP=1,  N=4, DELAY=3  (one-cycle request pulse)
// -----------------------------------------------------------------------------
module tb_angle_host_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    logic       a_kick = 1'b0, a_req = 1'b0;
    logic [7:0] a_angle;
    logic       a_has, a_ack, a_busy, a_done;

    logic       b_kick = 1'b0, b_req = 1'b0;
    logic [7:0] b_angle;
    logic       b_has, b_ack, b_busy, b_done;

    logic       c_kick = 1'b0, c_req = 1'b0;
    logic [7:0] c_angle;
    logic       c_has, c_ack, c_busy, c_done;

    angle_host_sequencer #(
        .ANGLE_LENGTH(8), .ANGLE_START(10), .ANGLE_STEP(60),
        .NO_OF_ANGLES(3), .ACK_DELAY(2)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .kick(a_kick), .hs_next_angle(a_req),
        .hs_angle(a_angle), .hs_has_next_angle(a_has),
        .hs_next_angle_ack(a_ack), .busy(a_busy), .done(a_done)
    );

    angle_host_sequencer #(
        .ANGLE_LENGTH(8), .ANGLE_START(200), .ANGLE_STEP(60),
        .NO_OF_ANGLES(2), .ACK_DELAY(2)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .kick(b_kick), .hs_next_angle(b_req),
        .hs_angle(b_angle), .hs_has_next_angle(b_has),
        .hs_next_angle_ack(b_ack), .busy(b_busy), .done(b_done)
    );

    angle_host_sequencer #(
        .ANGLE_LENGTH(8), .ANGLE_START(0), .ANGLE_STEP(1),
        .NO_OF_ANGLES(4), .ACK_DELAY(3)
    ) u_c (
        .clk(clk), .reset_n(reset_n), .kick(c_kick), .hs_next_angle(c_req),
        .hs_angle(c_angle), .hs_has_next_angle(c_has),
        .hs_next_angle_ack(c_ack), .busy(c_busy), .done(c_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Inputs are driven just after a falling edge, sampled at the next rising
    // edge, and the outputs are compared at the falling edge after that.
    typedef struct {
        logic       kick;
        logic       req;
        logic       ack;
        logic [7:0] angle;
        logic       has_next;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int         ack_cnt;
        logic [7:0] ack_angles[2];

        // ---------------- table for u_a: one full scan, request held high ----
        //               kick  req  ack angle has busy done
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd10,  1'b1, 1'b1, 1'b0}; // -> WAIT_REQ
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'd10,  1'b1, 1'b1, 1'b0}; // -> DELAY
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'd10,  1'b1, 1'b1, 1'b0}; // -> ACK #1
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'd70,  1'b1, 1'b1, 1'b0}; // -> HOLD
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'd70,  1'b1, 1'b1, 1'b0}; // -> WAIT_REQ
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'd70,  1'b1, 1'b1, 1'b0}; // kick ignored
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'd70,  1'b1, 1'b1, 1'b0}; // -> ACK #2
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'd130, 1'b1, 1'b1, 1'b0}; // -> HOLD
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'd130, 1'b1, 1'b1, 1'b0}; // -> WAIT_REQ
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'd130, 1'b1, 1'b1, 1'b0}; // kick ignored
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'd130, 1'b1, 1'b1, 1'b0}; // -> ACK #3
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'd190, 1'b0, 1'b1, 1'b1}; // -> DONE
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'd190, 1'b0, 1'b0, 1'b0}; // -> IDLE
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'd190, 1'b0, 1'b0, 1'b0}; // late req
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'd190, 1'b0, 1'b0, 1'b0};

        // ---------------- asynchronous reset ---------------------------------
        #1 reset_n = 1'b0;
        #1;
        check("rst a_angle", a_angle, 10);
        check("rst a_has",   a_has,   0);
        check("rst a_ack",   a_ack,   0);
        check("rst a_busy",  a_busy,  0);
        check("rst a_done",  a_done,  0);
        check("rst b_angle", b_angle, 200);
        check("rst c_angle", c_angle, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // ---------------- table-driven scan ----------------------------------
        for (int i = 0; i < 15; i++) begin
            a_kick = vecs[i].kick;
            a_req  = vecs[i].req;
            @(negedge clk);
            check($sformatf("vec%0d ack", i),   a_ack,   vecs[i].ack);
            check($sformatf("vec%0d angle", i), a_angle, vecs[i].angle);
            check($sformatf("vec%0d has", i),   a_has,   vecs[i].has_next);
            check($sformatf("vec%0d busy", i),  a_busy,  vecs[i].busy);
            check($sformatf("vec%0d done", i),  a_done,  vecs[i].done);
        end
        a_kick = 1'b0;

        // ---------------- request held before kick, held through HOLD --------
        a_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("idle_req%0d ack", i), a_ack, 0);
        end
        a_kick = 1'b1;
        @(negedge clk);                       // k = 0: first WAIT_REQ cycle
        a_kick = 1'b0;
        check("prekick k0 ack",  a_ack,  0);
        check("prekick k0 busy", a_busy, 1);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check($sformatf("prekick k%0d ack", k), a_ack,
                  ((k % 4 == 2) && (k <= 10)) ? 1 : 0);
            if ((k % 4 == 2) && (k <= 10))
                check($sformatf("prekick k%0d angle", k), a_angle, 10 + 60 * (k / 4));
            check($sformatf("prekick k%0d done", k), a_done, (k == 11) ? 1 : 0);
        end
        check("prekick end busy", a_busy, 0);
        check("prekick end has",  a_has,  0);
        a_req = 1'b0;

        // ---------------- angle wrap on u_b ----------------------------------
        b_req  = 1'b1;
        b_kick = 1'b1;
        @(negedge clk);
        b_kick  = 1'b0;
        ack_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (b_ack) begin
                if (ack_cnt < 2) ack_angles[ack_cnt] = b_angle;
                check($sformatf("wrap ack%0d has", ack_cnt), b_has, 1);
                ack_cnt++;
            end
            check($sformatf("wrap k%0d done", k), b_done, (k == 7) ? 1 : 0);
        end
        b_req = 1'b0;
        check("wrap ack count",  ack_cnt, 2);
        check("wrap angle0",     ack_angles[0], 200);
        check("wrap angle1",     ack_angles[1], 4);
        check("wrap final angle", b_angle, 64);
        check("wrap final has",   b_has,   0);

        // ---------------- one-cycle request pulse, DELAY=3, on u_c -----------
        c_kick = 1'b1;
        @(negedge clk);                       // WAIT_REQ
        c_kick = 1'b0;
        c_req  = 1'b1;
        @(negedge clk);                       // k = 1: request sampled -> DELAY
        c_req = 1'b0;
        check("pulse k1 ack", c_ack, 0);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("pulse k%0d ack", k), c_ack, (k == 3) ? 1 : 0);
        end
        check("pulse angle", c_angle, 1);
        check("pulse has",   c_has,   1);
        check("pulse busy",  c_busy,  1);

        // ---------------- async reset during DELAY on u_a --------------------
        a_req  = 1'b1;
        a_kick = 1'b1;
        @(negedge clk);                       // k = 0
        a_kick = 1'b0;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        check("prerst angle", a_angle, 70);   // second service, in DELAY
        check("prerst busy",  a_busy,  1);
        a_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;                                   // still before the next rising edge
        check("midrst angle", a_angle, 10);
        check("midrst has",   a_has,   0);
        check("midrst busy",  a_busy,  0);
        check("midrst ack",   a_ack,   0);
        check("midrst done",  a_done,  0);
        check("midrst c_busy", c_busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        ack_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (a_ack || a_done) ack_cnt++;
        end
        check("postrst no ack", ack_cnt, 0);
        check("postrst busy",   a_busy,  0);

        a_req  = 1'b1;
        a_kick = 1'b1;
        @(negedge clk);
        a_kick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("restart ack",   a_ack,   1);
        check("restart angle", a_angle, 10);
        a_req = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/angle_host_sequencer.md
Name: angle_host_sequencer

Overview:
- Host-side responder for the angle request handshake consumed by the filtered RAM swap control.
- Serves one projection scan after `kick`: answers each `hs_next_angle` request with a one-cycle `hs_next_angle_ack`, after a fixed lookup latency.
- Presents the angle being delivered on `hs_angle`, and flags on `hs_has_next_angle` whether any undelivered angle remains.
- Sits between the top-level scan controller and the swap control's host port.

Parameters:
ANGLE_LENGTH, 8, width of hs_angle (matches kAngleLength)
ANGLE_START, 0, first angle of a scan
ANGLE_STEP, 1, increment between consecutive angles (unsigned)
NO_OF_ANGLES, 180, angles per scan; legal range >=1
ACK_DELAY, 2, cycles from sampled request to ack; legal range >=1

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
kick  input  1  start-of-scan pulse; ignored unless idle
hs_next_angle  input  1  level request from swap control
hs_angle  output  ANGLE_LENGTH  angle delivered by the next ack
hs_has_next_angle  output  1  an undelivered angle remains in this scan
hs_next_angle_ack  output  1  single-cycle acknowledge; consumer latches hs_angle/hs_has_next_angle in this cycle
busy  output  1  scan in progress
done  output  1  single-cycle pulse after the last angle is acked

Behaviour:
- Reset is asynchronous active-low. While asserted: state=IDLE, hs_angle=ANGLE_START, hs_has_next_angle=0, hs_next_angle_ack=0, busy=0, done=0, remaining=0, delay counter=0.
- Reset mid-scan aborts the scan immediately. No ack or done is issued for it.
- All outputs are registered; none is combinational from any input.
- `remaining` counter: width clog2(NO_OF_ANGLES+1). `angle` register: ANGLE_LENGTH bits; increments modulo 2^ANGLE_LENGTH (wraps silently).
- hs_has_next_angle = busy && (remaining != 0). It is valid in every cycle, including the ack cycle.
- States: IDLE, WAIT_REQ, DELAY, ACK, HOLD, DONE.
- IDLE:
  - hs_next_angle is ignored.
  - kick=1 -> load angle=ANGLE_START, remaining=NO_OF_ANGLES, busy=1; go to WAIT_REQ.
- WAIT_REQ: hs_next_angle=1 sampled ->
  - if ACK_DELAY==1, go to ACK;
  - else load delay counter with ACK_DELAY-1 and go to DELAY.
  - A request already high at kick is therefore served.
- DELAY:
  - Decrement the counter; at the cycle the counter reaches 0, go to ACK.
  - Ack is therefore asserted exactly ACK_DELAY cycles after the sampling edge.
  - The request is latched: a drop of hs_next_angle during DELAY does not cancel the ack.
- ACK:
  - hs_next_angle_ack=1 for exactly this cycle, with hs_angle and hs_has_next_angle=1 describing the delivered angle.
  - At the end of the cycle: angle += ANGLE_STEP, remaining -= 1.
  - Go to HOLD if remaining>1 before the decrement; else go to DONE.
- HOLD:
  - One cycle in which hs_next_angle is ignored. This covers the consumer dropping its request the cycle after ack, and prevents a double ack.
  - Then go to WAIT_REQ.
- DONE:
  - done=1 for one cycle; hs_has_next_angle is already 0; busy=0 from the next cycle.
  - Requests arriving now or later get no ack; the consumer proceeds via its release path.
  - Then go to IDLE.
- kick while busy is ignored. Simultaneous kick and request in IDLE: kick is taken; the request is sampled from WAIT_REQ onward.
- Steady-state throughput with the request held continuously high: one ack per ACK_DELAY+2 cycles.
- hs_angle holds its final value (START + N*STEP mod 2^ANGLE_LENGTH) after DONE until the next kick or reset.

Test Plan:
- Setup for the first scenario: START=10, STEP=60, N=3, DELAY=2. Kick, then hold the request high -> acks at 2-cycle latency with 4-cycle spacing; hs_angle at the acks = 10, 70, 130; hs_has_next_angle=1 at each ack and 0 from the cycle after the 3rd ack; done pulses once, one cycle after the 3rd ack.
- Request held high before kick -> first ack exactly ACK_DELAY cycles after the first WAIT_REQ cycle; no ack ever while IDLE.
- Wrap: ANGLE_LENGTH=8, START=200, STEP=60, N=2 -> hs_angle at the acks = 200, 4; final hs_angle = 64.
- Request pulsed for 1 cycle, DELAY=3 -> ack still issued 3 cycles later. Request held through HOLD -> exactly one ack per service.
- Request after done -> no ack, hs_has_next_angle stays 0. Kick during busy -> no reload, angle sequence unchanged.
- reset_n dropped asynchronously in DELAY -> all outputs go to reset values before the next clk edge; no ack follows; a fresh kick restarts at ANGLE_START.
